// File: rtl/am_pkg.sv
// am_pkg: shared widths, FSM state encoding and constants for the
// 16-by-8 sequential restoring divider (am_divider).
package am_pkg;

    localparam int DW = 16;
    localparam int VW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [DW-1:0] DIV0_QUOT = 16'hFFFF;

endpackage

// File: rtl/am_div_step.sv
// am_div_step: one combinational restoring-division iteration.
// Ports: r_i partial remainder, q_msb_i next dividend bit, d_i divisor;
//        r_o next partial remainder, qbit_o produced quotient bit.
module am_div_step #(
    parameter int VW = 8
) (
    input  logic [VW:0]   r_i,
    input  logic          q_msb_i,
    input  logic [VW-1:0] d_i,
    output logic [VW:0]   r_o,
    output logic          qbit_o
);

    // r_i never exceeds d_i-1, so its top bit is 0 and {r_i, msb}
    // equals {r_i[VW-1:0], msb}; the wide form keeps every bit live.
    logic [VW+1:0] t;
    logic [VW+1:0] d_ext;

    always_comb begin
        t     = {r_i, q_msb_i};
        d_ext = {2'b00, d_i};
        if (t >= d_ext) begin
            r_o    = (VW+1)'(t - d_ext);
            qbit_o = 1'b1;
        end else begin
            r_o    = t[VW:0];
            qbit_o = 1'b0;
        end
    end

endmodule

// File: rtl/am_divider.sv
// am_divider: sequential unsigned DW/VW restoring divider, one quotient
// bit per clock behind a start/busy/done handshake.
// Ports: clk, rst_n; start, dividend, divisor (sampled when not busy);
//        busy, done (1-cycle pulse), quotient, remainder, div_by_zero.
module am_divider
    import am_pkg::*;
#(
    parameter int DW = am_pkg::DW,
    parameter int VW = am_pkg::VW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam logic [3:0] LAST_CNT = 4'(DW - 1);

    state_e state_q, state_d;

    logic [VW:0]   r_q, r_d;
    logic [DW-1:0] q_q, q_d;
    logic [VW-1:0] d_q, d_d;
    logic [3:0]    cnt_q, cnt_d;

    logic [DW-1:0] quotient_q, quotient_d;
    logic [VW-1:0] remainder_q, remainder_d;
    logic          dbz_q, dbz_d;

    logic [VW:0]   r_next;
    logic          qbit;
    logic [DW-1:0] q_next;

    logic accept;
    logic last;

    am_div_step #(.VW(VW)) u_step (
        .r_i     (r_q),
        .q_msb_i (q_q[DW-1]),
        .d_i     (d_q),
        .r_o     (r_next),
        .qbit_o  (qbit)
    );

    assign q_next = {q_q[DW-2:0], qbit};
    assign accept = start && (state_q != CALC);
    assign last   = (cnt_q == LAST_CNT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE accepts a start just like IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = (divisor == '0) ? DONE : CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            CALC:    busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values
    always_comb begin
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        if (accept) begin
            r_d   = '0;
            q_d   = dividend;
            d_d   = divisor;
            cnt_d = '0;
            dbz_d = 1'b0;
            // Divide by zero finishes without any CALC cycles
            if (divisor == '0) begin
                quotient_d  = DW'(DIV0_QUOT);
                remainder_d = dividend[VW-1:0];
                dbz_d       = 1'b1;
            end
        end else if (state_q == CALC) begin
            r_d   = r_next;
            q_d   = q_next;
            cnt_d = cnt_q + 4'd1;
            if (last) begin
                quotient_d  = q_next;
                remainder_d = r_next[VW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_am_divider.sv
// tb_am_divider: directed and swept self-checking bench for am_divider.
// Latency is counted in clock edges after the start-sampling edge.
module tb_am_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int n_run  = 0;
    int n_fail = 0;

    am_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present operands with start for one edge, then scramble the bus
    task automatic kick(input logic [15:0] a, input logic [7:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'hDEAD;
        divisor  = 8'h00;
    endtask

    // Bounded wait for done; lat = edges since entry, bc = busy cycles
    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (!done && lat < 40) begin
            if (busy) bc++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_res(input string tag, input logic [15:0] eq,
                             input logic [7:0] er, input logic edz);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_q"}, 32'(quotient), 32'(eq));
        check({tag, "_r"}, 32'(remainder), 32'(er));
        check({tag, "_dz"}, 32'(div_by_zero), 32'(edz));
    endtask

    task automatic run_div(input string tag, input logic [15:0] a,
                           input logic [7:0] b, input logic [15:0] eq,
                           input logic [7:0] er, input logic edz,
                           input int elat);
        int lat;
        int bc;
        kick(a, b);
        wait_done(lat, bc);
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_busycyc"}, 32'(bc), 32'(elat));
        check_res(tag, eq, er, edz);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int bc;
        int ndone;
        logic [15:0] a;
        logic [7:0]  b;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_div("fe01", 16'hFE01, 8'hFF, 16'h00FF, 8'h00, 1'b0, 16);
        run_div("1000_7", 16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0, 16);
        run_div("ffff_1", 16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 16);
        run_div("12_20", 16'h0012, 8'h20, 16'h0000, 8'h12, 1'b0, 16);
        run_div("dz", 16'h0005, 8'h00, 16'hFFFF, 8'h05, 1'b1, 0);
        run_div("dz_clr", 16'h0010, 8'h04, 16'h0004, 8'h00, 1'b0, 16);

        // start pulse during CALC must be ignored
        kick(16'h03E8, 8'h07);
        repeat (5) @(posedge clk);
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'hFFFF;
        divisor  = 8'h01;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bc);
        check("mid_lat", 32'(lat), 32'd10);
        check_res("mid", 16'h008E, 8'h06, 1'b0);
        @(posedge clk);
        #1;
        check("mid_pulse", 32'(done), 32'd0);

        // start held through done: second op accepted on the done cycle
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'hFE01;
        divisor  = 8'hFF;
        @(posedge clk);
        #1;
        dividend = 16'h0064;
        divisor  = 8'h0A;
        wait_done(lat, bc);
        check("b2b1_lat", 32'(lat), 32'd16);
        check_res("b2b1", 16'h00FF, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_gap", 32'(done), 32'd0);
        wait_done(lat, bc);
        check("b2b2_lat", 32'(lat + 1), 32'd17);
        check_res("b2b2", 16'h000A, 8'h00, 1'b0);

        // reset in the middle of CALC aborts with no done pulse
        kick(16'h1234, 8'h05);
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_q", 32'(quotient), 32'd0);
        check("abort_r", 32'(remainder), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_dz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("abort_nodone", 32'(ndone), 32'd0);
        run_div("post", 16'h0064, 8'h0A, 16'h000A, 8'h00, 1'b0, 16);

        // sweep against the arithmetic reference
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            b = 8'($urandom_range(1, 255));
            kick(a, b);
            wait_done(lat, bc);
            check("rnd_done", 32'(done), 32'd1);
            check("rnd_q", 32'(quotient), 32'(a / 16'(b)));
            check("rnd_r", 32'(remainder), 32'(a % 16'(b)));
            check("rnd_recon", 32'(quotient) * 32'(b) + 32'(remainder),
                  32'(a));
            check("rnd_rlt", 32'(remainder < b), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
